// File: rtl/inst_fetcher_if.sv
// Fetcher <-> memory controller read port.
// Single-word request pulse, single-cycle response pulse.
interface inst_fetcher_if;
  logic        out_mem_ce;
  logic [31:0] out_mem_addr;
  logic        in_mem_ce;
  logic [31:0] in_mem_data;

  modport master (
    output out_mem_ce,
    output out_mem_addr,
    input  in_mem_ce,
    input  in_mem_data
  );

  modport slave (
    input  out_mem_ce,
    input  out_mem_addr,
    output in_mem_ce,
    output in_mem_data
  );
endinterface

// File: rtl/inst_fetcher.sv
// Instruction fetch stage with a direct-mapped one-word-per-line
// I-cache; misses go to the memory controller one word at a time.
module inst_fetcher #(
  parameter int ICACHE_INDEX_BITS = 8,
  parameter int ADDR_BITS         = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                in_rob_misbranch,
  input  logic [31:0]         in_rob_newpc,
  input  logic                in_dispatch_stall,
  inst_fetcher_if.master      mem,
  output logic                out_inst_valid,
  output logic [31:0]         out_inst,
  output logic [31:0]         out_pc
);

  localparam int LINES = 1 << ICACHE_INDEX_BITS;
  localparam int TAG_W = ADDR_BITS - ICACHE_INDEX_BITS - 2;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t                         state, state_n;
  logic [31:0]                    pc, pc_n;
  logic [LINES-1:0]               valid;
  logic [TAG_W-1:0]               tags  [LINES];
  logic [31:0]                    words [LINES];
  logic [ICACHE_INDEX_BITS-1:0]   idx;
  logic [TAG_W-1:0]               ptag;
  logic                           hit;
  logic                           issue;
  logic                           req;
  logic                           fill;
  logic [31:0]                    word;

  assign idx  = pc[ICACHE_INDEX_BITS+1:2];
  assign ptag = pc[ADDR_BITS-1:ICACHE_INDEX_BITS+2];
  assign hit  = valid[idx] && (tags[idx] == ptag);

  // Next-state and per-cycle actions; misbranch overrides everything.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    issue   = 1'b0;
    req     = 1'b0;
    fill    = 1'b0;
    word    = words[idx];
    if (in_rob_misbranch) begin
      pc_n    = in_rob_newpc;
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!hit) begin
            req     = 1'b1;
            state_n = WAIT_MEM;
          end else if (!in_dispatch_stall) begin
            issue = 1'b1;
            pc_n  = pc + 32'd4;
          end
        end
        WAIT_MEM: begin
          if (mem.in_mem_ce) begin
            fill    = 1'b1;
            word    = mem.in_mem_data;
            state_n = IDLE;
            if (!in_dispatch_stall) begin
              issue = 1'b1;
              pc_n  = pc + 32'd4;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_n;
  end

  // PC, valid bits and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc               <= '0;
      valid            <= '0;
      mem.out_mem_ce   <= 1'b0;
      mem.out_mem_addr <= '0;
      out_inst_valid   <= 1'b0;
      out_inst         <= '0;
      out_pc           <= '0;
    end else if (rdy) begin
      pc             <= pc_n;
      out_inst_valid <= issue;
      mem.out_mem_ce <= req;
      if (req)   mem.out_mem_addr <= pc;
      if (fill)  valid[idx] <= 1'b1;
      if (issue) begin
        out_inst <= word;
        out_pc   <= pc;
      end
    end
  end

  // Cache data/tag arrays; no reset, validity lives in valid.
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tags[idx]  <= ptag;
      words[idx] <= mem.in_mem_data;
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a fixed-latency memory
// responder; memory word at address a is {a[23:0], 8'h13}.
module tb_inst_fetcher;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        in_rob_misbranch;
  logic [31:0] in_rob_newpc;
  logic        in_dispatch_stall;
  logic        out_inst_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  inst_fetcher_if mif ();

  inst_fetcher dut (
    .clk               (clk),
    .rst               (rst),
    .rdy               (rdy),
    .in_rob_misbranch  (in_rob_misbranch),
    .in_rob_newpc      (in_rob_newpc),
    .in_dispatch_stall (in_dispatch_stall),
    .mem               (mif),
    .out_inst_valid    (out_inst_valid),
    .out_inst          (out_inst),
    .out_pc            (out_pc)
  );

  int          n_cmp;
  int          n_err;
  int          cyc;
  int          lat;
  logic        pend;
  int          wcnt;
  logic [31:0] paddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; sample #1 after the edge, then run the responder.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    mif.in_mem_ce = 1'b0;
    if (mif.out_mem_ce) begin
      pend  = 1'b1;
      wcnt  = lat;
      paddr = mif.out_mem_addr;
    end
    if (pend) begin
      wcnt--;
      if (wcnt == 0) begin
        mif.in_mem_ce   = 1'b1;
        mif.in_mem_data = mem_word(paddr);
        pend            = 1'b0;
      end
    end
  endtask

  task automatic wait_issue(input string tag, input logic [31:0] p);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (out_inst_valid && out_pc == p) found = 1'b1;
    end
    chk({tag, "_seen"}, {31'b0, found}, 32'd1);
    if (found) chk({tag, "_inst"}, out_inst, mem_word(p));
  endtask

  task automatic wait_resp(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (mif.in_mem_ce) found = 1'b1;
    end
    chk({tag, "_resp"}, {31'b0, found}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] p);
    in_rob_misbranch = 1'b1;
    in_rob_newpc     = p;
    tick();
    in_rob_misbranch = 1'b0;
  endtask

  task automatic chk_req(input string tag, input logic [31:0] a);
    chk({tag, "_ce"},   {31'b0, mif.out_mem_ce}, 32'd1);
    chk({tag, "_addr"}, mif.out_mem_addr, a);
  endtask

  initial begin
    int t0;
    n_cmp             = 0;
    n_err             = 0;
    cyc               = 0;
    lat               = 5;
    pend              = 1'b0;
    wcnt              = 0;
    paddr             = '0;
    rst               = 1'b1;
    rdy               = 1'b1;
    in_rob_misbranch  = 1'b0;
    in_rob_newpc      = '0;
    in_dispatch_stall = 1'b0;
    mif.in_mem_ce     = 1'b0;
    mif.in_mem_data   = '0;

    tick();
    tick();
    chk("rst_ce",    {31'b0, mif.out_mem_ce}, 32'd0);
    chk("rst_addr",  mif.out_mem_addr, 32'd0);
    chk("rst_valid", {31'b0, out_inst_valid}, 32'd0);
    chk("rst_inst",  out_inst, 32'd0);
    chk("rst_pc",    out_pc, 32'd0);

    // First fetch after reset: miss at 0, 5-cycle memory.
    rst = 1'b0;
    tick();
    chk_req("req0", 32'd0);
    t0 = cyc;
    wait_issue("iss0", 32'd0);
    chk("iss0_lat", cyc - t0, 32'd5);
    tick();
    chk_req("req4", 32'd4);

    // Cold pass over 4..12, then replay 0..12 from the cache.
    wait_issue("iss4", 32'd4);
    wait_issue("iss8", 32'd8);
    wait_issue("iss12", 32'd12);
    redirect(32'd0);
    chk("mb_valid", {31'b0, out_inst_valid}, 32'd0);
    chk("mb_ce",    {31'b0, mif.out_mem_ce}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("loop_valid", {31'b0, out_inst_valid}, 32'd1);
      chk("loop_pc",    out_pc, 32'(i * 4));
      chk("loop_ce",    {31'b0, mif.out_mem_ce}, 32'd0);
    end
    tick();
    chk_req("req16", 32'd16);
    wait_issue("iss16", 32'd16);

    // Stall on a hit holds the pc.
    in_dispatch_stall = 1'b1;
    redirect(32'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'b0, out_inst_valid}, 32'd0);
      chk("stall_ce",    {31'b0, mif.out_mem_ce}, 32'd0);
    end
    in_dispatch_stall = 1'b0;
    tick();
    chk("unstall_valid", {31'b0, out_inst_valid}, 32'd1);
    chk("unstall_pc",    out_pc, 32'd4);

    // Misbranch coinciding with the response for 20 drops it.
    wait_resp("r20");
    redirect(32'h100);
    chk("drop_valid", {31'b0, out_inst_valid}, 32'd0);
    tick();
    chk_req("req100", 32'h100);
    wait_issue("iss100", 32'h100);
    redirect(32'd20);
    tick();
    chk_req("req20", 32'd20);
    wait_issue("iss20", 32'd20);

    // Response under stall fills only; issue later as a hit.
    redirect(32'h20);
    tick();
    chk_req("req20h", 32'h20);
    wait_resp("r20h");
    in_dispatch_stall = 1'b1;
    tick();
    chk("fill_valid", {31'b0, out_inst_valid}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("fill_hold_valid", {31'b0, out_inst_valid}, 32'd0);
      chk("fill_hold_ce",    {31'b0, mif.out_mem_ce}, 32'd0);
    end
    in_dispatch_stall = 1'b0;
    tick();
    chk("fill_iss_valid", {31'b0, out_inst_valid}, 32'd1);
    chk("fill_iss_pc",    out_pc, 32'h20);
    chk("fill_iss_inst",  out_inst, mem_word(32'h20));
    chk("fill_iss_ce",    {31'b0, mif.out_mem_ce}, 32'd0);

    // 0x400 shares index 0 with 0x0 and evicts it.
    redirect(32'h400);
    tick();
    chk_req("req400", 32'h400);
    wait_issue("iss400", 32'h400);
    redirect(32'd0);
    tick();
    chk_req("req0b", 32'd0);
    wait_issue("iss0b", 32'd0);

    // PC wraps from 0xFFFFFFFC onto the cached line at 0.
    redirect(32'hFFFF_FFFC);
    tick();
    chk_req("reqtop", 32'hFFFF_FFFC);
    wait_issue("isstop", 32'hFFFF_FFFC);
    tick();
    chk("wrap_valid", {31'b0, out_inst_valid}, 32'd1);
    chk("wrap_pc",    out_pc, 32'd0);
    chk("wrap_ce",    {31'b0, mif.out_mem_ce}, 32'd0);

    // rdy low freezes every register.
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rdy_valid", {31'b0, out_inst_valid}, 32'd1);
      chk("rdy_pc",    out_pc, 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("rdy_resume_valid", {31'b0, out_inst_valid}, 32'd1);
    chk("rdy_resume_pc",    out_pc, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
